// File: rtl/d_mem_ctrl.sv
// d_mem_ctrl: single-outstanding data-memory controller behind the LSQ, fixed MEM_LATENCY access.
// Optional build macro D_MEM_CTRL_MISALIGN_CHECK_EN adds mem_ctrl_err for misaligned requests.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 32
`endif

package d_mem_ctrl_pkg;
   typedef enum logic [1:0] {
      no_mem_op = 2'd0,
      mem_read  = 2'd1,
      mem_write = 2'd2
   } memory_op_t;
endpackage

module d_mem_ctrl
   import d_mem_ctrl_pkg::*;
#(
   parameter int MEM_LATENCY     = 2,
   parameter int MEM_DEPTH_WORDS = 1024
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            lsq_req_valid,
   input  memory_op_t                      lsq_req_op,
   input  logic [`D_MEMORY_ADDR_WIDTH-1:0] lsq_req_address,
   input  logic [`REG_VAL_WIDTH-1:0]       lsq_req_data,
`ifdef D_MEM_CTRL_MISALIGN_CHECK_EN
   output logic                            mem_ctrl_err,
`endif
   output logic                            mem_ctrl_ready,
   output logic                            mem_ctrl_done,
   output logic [`REG_VAL_WIDTH-1:0]       mem_ctrl_data
);

   localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                     state;
   logic [3:0]                 lat_cnt;
   memory_op_t                 req_op;
   logic [IDX_W-1:0]           req_idx;
   logic [`REG_VAL_WIDTH-1:0]  req_data;
   logic                       req_mis;
   logic [`REG_VAL_WIDTH-1:0]  mem [MEM_DEPTH_WORDS];

   logic accept, commit, mis_now, wr_ok, rd_ok, unused_addr;

   assign accept = lsq_req_valid && (lsq_req_op != no_mem_op);
   assign commit = (state == ACCESS) && (lat_cnt == 4'd0);
   assign wr_ok  = commit && (req_op == mem_write) && !req_mis;
   assign rd_ok  = commit && (req_op == mem_read) && !req_mis;
   // Upper address bits beyond the array wrap away; low bits matter only with the check.
   assign unused_addr = ^lsq_req_address;

`ifdef D_MEM_CTRL_MISALIGN_CHECK_EN
   assign mis_now = |lsq_req_address[1:0];
`else
   assign mis_now = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         lat_cnt        <= 4'd0;
         req_op         <= no_mem_op;
         req_idx        <= '0;
         req_data       <= '0;
         req_mis        <= 1'b0;
         mem_ctrl_ready <= 1'b1;
         mem_ctrl_done  <= 1'b0;
         mem_ctrl_data  <= '0;
`ifdef D_MEM_CTRL_MISALIGN_CHECK_EN
         mem_ctrl_err   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               mem_ctrl_done <= 1'b0;
`ifdef D_MEM_CTRL_MISALIGN_CHECK_EN
               mem_ctrl_err  <= 1'b0;
`endif
               if (accept) begin
                  req_op         <= lsq_req_op;
                  req_idx        <= lsq_req_address[IDX_W+1:2];
                  req_data       <= lsq_req_data;
                  req_mis        <= mis_now;
                  lat_cnt        <= 4'(MEM_LATENCY - 1);
                  mem_ctrl_ready <= 1'b0;
                  state          <= ACCESS;
               end
            end
            ACCESS: begin
               if (lat_cnt == 4'd0) begin
                  if (rd_ok) mem_ctrl_data <= mem[req_idx];
                  mem_ctrl_done <= 1'b1;
`ifdef D_MEM_CTRL_MISALIGN_CHECK_EN
                  mem_ctrl_err  <= req_mis;
`endif
                  state         <= RESP;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            RESP: begin
               mem_ctrl_done  <= 1'b0;
`ifdef D_MEM_CTRL_MISALIGN_CHECK_EN
               mem_ctrl_err   <= 1'b0;
`endif
               mem_ctrl_ready <= 1'b1;
               state          <= IDLE;
            end
            default: begin
               state          <= IDLE;
               mem_ctrl_ready <= 1'b1;
               mem_ctrl_done  <= 1'b0;
            end
         endcase
      end
   end

   // Array is never reset; a commit edge that coincides with reset is dropped.
   always_ff @(posedge clk) begin
      if (!reset && wr_ok) mem[req_idx] <= req_data;
   end

endmodule

// File: tb/tb_d_mem_ctrl.sv
// Bench for d_mem_ctrl: vector table, hand-written corner sequences and random traffic vs a word-array model.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 32
`endif

module tb_d_mem_ctrl;
   import d_mem_ctrl_pkg::*;

   localparam int L = 2;
   localparam int D = 1024;

   logic                            clk = 1'b0;
   logic                            reset = 1'b1;
   logic                            lsq_req_valid = 1'b0;
   memory_op_t                      lsq_req_op = no_mem_op;
   logic [`D_MEMORY_ADDR_WIDTH-1:0] lsq_req_address = '0;
   logic [`REG_VAL_WIDTH-1:0]       lsq_req_data = '0;
   logic                            mem_ctrl_ready, mem_ctrl_done;
   logic [`REG_VAL_WIDTH-1:0]       mem_ctrl_data;
`ifdef D_MEM_CTRL_MISALIGN_CHECK_EN
   logic                            mem_ctrl_err;
`endif

   d_mem_ctrl #(.MEM_LATENCY(L), .MEM_DEPTH_WORDS(D)) dut (
      .clk             (clk),
      .reset           (reset),
      .lsq_req_valid   (lsq_req_valid),
      .lsq_req_op      (lsq_req_op),
      .lsq_req_address (lsq_req_address),
      .lsq_req_data    (lsq_req_data),
`ifdef D_MEM_CTRL_MISALIGN_CHECK_EN
      .mem_ctrl_err    (mem_ctrl_err),
`endif
      .mem_ctrl_ready  (mem_ctrl_ready),
      .mem_ctrl_done   (mem_ctrl_done),
      .mem_ctrl_data   (mem_ctrl_data)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model [int];
   logic [31:0] last_data = 32'h0;
   int          widx [$];

   typedef struct {
      memory_op_t  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction with exact cycle-by-cycle timing; model updated at the commit point.
   task automatic do_req(input memory_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] got);
      int idx;
      bit mis;
      idx = int'((addr >> 2) % D);
      mis = 1'b0;
`ifdef D_MEM_CTRL_MISALIGN_CHECK_EN
      mis = (addr[1:0] != 2'b00);
`endif
      check("ready_idle", {31'b0, mem_ctrl_ready}, 32'd1);
      lsq_req_valid = 1'b1; lsq_req_op = op; lsq_req_address = addr; lsq_req_data = wd;
      tick();
      lsq_req_valid = 1'b0; lsq_req_op = no_mem_op;
      check("ready_busy", {31'b0, mem_ctrl_ready}, 32'd0);
      check("done_early", {31'b0, mem_ctrl_done}, 32'd0);
      for (int c = 1; c < L; c++) begin
         tick();
         check("ready_busy", {31'b0, mem_ctrl_ready}, 32'd0);
         check("done_early", {31'b0, mem_ctrl_done}, 32'd0);
      end
      tick();
      if (op == mem_write && !mis) begin
         if (!model.exists(idx)) widx.push_back(idx);
         model[idx] = wd;
      end
      if (op == mem_read && !mis && model.exists(idx)) last_data = model[idx];
      check("done_pulse", {31'b0, mem_ctrl_done}, 32'd1);
      check("ready_resp", {31'b0, mem_ctrl_ready}, 32'd0);
      check("data_resp", mem_ctrl_data, last_data);
`ifdef D_MEM_CTRL_MISALIGN_CHECK_EN
      check("err_resp", {31'b0, mem_ctrl_err}, {31'b0, mis});
`endif
      got = mem_ctrl_data;
      tick();
      check("done_clear", {31'b0, mem_ctrl_done}, 32'd0);
      check("ready_back", {31'b0, mem_ctrl_ready}, 32'd1);
      check("data_hold", mem_ctrl_data, last_data);
   endtask

   initial begin
      logic [31:0] got;
      vecs[0] = '{mem_write, 32'h10,          32'hDEADBEEF, 32'h0};
      vecs[1] = '{mem_read,  32'h10,          32'h0,        32'hDEADBEEF};
      vecs[2] = '{mem_write, D*4 + 32'h10,    32'h1234,     32'hDEADBEEF};
      vecs[3] = '{mem_read,  32'h10,          32'h0,        32'h1234};
      vecs[4] = '{mem_write, 32'hFFC,         32'hCAFEF00D, 32'h1234};
      vecs[5] = '{mem_read,  32'h1FFC,        32'h0,        32'hCAFEF00D};

      // reset and idle
      repeat (3) tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_ready", {31'b0, mem_ctrl_ready}, 32'd1);
         check("rst_done", {31'b0, mem_ctrl_done}, 32'd0);
         check("rst_data", mem_ctrl_data, 32'h0);
      end

      for (int i = 0; i < 6; i++) begin
         do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, got);
         check($sformatf("vec%0d_data", i), got, vecs[i].exp);
      end

      // request while busy is dropped: exactly one done pulse
      begin
         int pulses;
         pulses = 0;
         lsq_req_valid = 1'b1; lsq_req_op = mem_write; lsq_req_address = 32'h20; lsq_req_data = 32'h0BADF00D;
         tick();
         lsq_req_op = mem_read; lsq_req_address = 32'h20;
         for (int c = 0; c < L; c++) begin
            tick();
            if (mem_ctrl_done) pulses++;
         end
         lsq_req_valid = 1'b0; lsq_req_op = no_mem_op;
         for (int c = 0; c < 6; c++) begin
            tick();
            if (mem_ctrl_done) pulses++;
         end
         check("busy_drop_pulses", pulses, 32'd1);
         check("busy_drop_data", mem_ctrl_data, last_data);
         widx.push_back(8);
         model[8] = 32'h0BADF00D;
      end

      // no_mem_op with valid in IDLE
      lsq_req_valid = 1'b1; lsq_req_op = no_mem_op; lsq_req_address = 32'h40;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("nop_ready", {31'b0, mem_ctrl_ready}, 32'd1);
         check("nop_done", {31'b0, mem_ctrl_done}, 32'd0);
      end
      lsq_req_valid = 1'b0;

      // reset landing on the commit edge of a write
      do_req(mem_write, 32'h30, 32'hAAAA0001, got);
      lsq_req_valid = 1'b1; lsq_req_op = mem_write; lsq_req_address = 32'h30; lsq_req_data = 32'h5555;
      tick();
      lsq_req_valid = 1'b0; lsq_req_op = no_mem_op;
      for (int c = 1; c < L; c++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      last_data = 32'h0;
      check("rst_mid_done", {31'b0, mem_ctrl_done}, 32'd0);
      check("rst_mid_ready", {31'b0, mem_ctrl_ready}, 32'd1);
      check("rst_mid_data", mem_ctrl_data, 32'h0);
      tick();
      check("rst_mid_done2", {31'b0, mem_ctrl_done}, 32'd0);
      do_req(mem_read, 32'h30, 32'h0, got);
      check("rst_mid_prior", got, 32'hAAAA0001);

`ifdef D_MEM_CTRL_MISALIGN_CHECK_EN
      do_req(mem_read, 32'h11, 32'h0, got);
      check("mis_read_data", got, 32'hAAAA0001);
      do_req(mem_write, 32'h12, 32'h77777777, got);
      do_req(mem_read, 32'h10, 32'h0, got);
      check("mis_write_sup", got, 32'h1234);
`endif

      // random traffic against the word-array model
      for (int n = 0; n < 60; n++) begin
         memory_op_t  op;
         logic [31:0] addr, wd;
         int          w;
         op = ($urandom_range(0, 1) == 0) ? mem_write : mem_read;
         if (op == mem_read && widx.size() > 0) w = widx[$urandom_range(0, widx.size() - 1)];
         else begin
            op = mem_write;
            w  = $urandom_range(0, 31) * 32 + $urandom_range(0, 3);
         end
         addr = 32'(w) * 4 + 32'($urandom_range(0, 3)) * D * 4;
`ifndef D_MEM_CTRL_MISALIGN_CHECK_EN
         addr[1:0] = 2'($urandom_range(0, 3));
`endif
         wd = $urandom;
         do_req(op, addr, wd, got);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
